// File: rtl/prime_pkg.sv
// Shared definitions for the trial-division primality tester.
package prime_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] S_CLASSIFY = 3'd1;
    localparam logic [STATE_W-1:0] S_SQ_TEST  = 3'd2;
    localparam logic [STATE_W-1:0] S_DIV_WAIT = 3'd3;
    localparam logic [STATE_W-1:0] S_NEXT     = 3'd4;
    localparam logic [STATE_W-1:0] S_FINISH   = 3'd5;

    // Increment applied to the divisor: 2 is always followed by 3, then odd-only skips evens.
    function automatic logic [1:0] div_step(input logic d_is_two, input logic odd_only);
        return (d_is_two || !odd_only) ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/restoring_remainder.sv
// Multi-cycle restoring remainder unit: one quotient bit per cycle, MSB first.
// The first bit is resolved on the start edge so done rises exactly WIDTH cycles
// after the start cycle, with rem valid while done is high.
module restoring_remainder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] rem
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    // Shift in one dividend bit and subtract the divisor when it fits.
    function automatic logic [WIDTH-1:0] rem_step(input logic [WIDTH-1:0] r,
                                                  input logic             b,
                                                  input logic [WIDTH-1:0] dv);
        logic [WIDTH:0] t;
        t = {r, b};
        if (t >= {1'b0, dv}) begin
            t = t - {1'b0, dv};
        end
        return t[WIDTH-1:0];
    endfunction

    // Next-state for the iteration registers; a new start restarts the operation.
    always_comb begin
        rem_d  = rem_q;
        dvd_d  = dvd_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (start) begin
            rem_d = rem_step('0, dividend[WIDTH-1], divisor);
            dvd_d = dividend << 1;
            dvs_d = divisor;
            cnt_d = CNT_W'(WIDTH - 1);
        end else if (cnt_q != '0) begin
            rem_d  = rem_step(rem_q, dvd_q[WIDTH-1], dvs_q);
            dvd_d  = dvd_q << 1;
            cnt_d  = cnt_q - CNT_W'(1);
            done_d = (cnt_q == CNT_W'(1));
        end
    end

    // Iteration registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dvd_q  <= dvd_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign rem  = rem_q;

endmodule

// File: rtl/prime_tester_param.sv
// Trial-division primality tester, start/done slave.
// Divisors run from 2 while d*d <= N; each trial uses the restoring remainder unit.
module prime_tester_param
    import prime_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter bit          ODD_ONLY = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic             is_prime,
    output logic [WIDTH-1:0] factor,
    output logic [WIDTH-1:0] trials
);

    localparam int unsigned SQ_W = 2 * WIDTH;

    logic [STATE_W-1:0] state_q, state_d;
    logic [WIDTH-1:0]   n_q, n_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [WIDTH-1:0]   trials_q, trials_d;
    logic [WIDTH-1:0]   factor_q, factor_d;
    logic               is_prime_q, is_prime_d;
    logic               div_start_q, div_start_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               div_done;
    logic [WIDTH-1:0]   div_rem;
    logic [SQ_W-1:0]    sq_c;
    logic               sq_gt_c;

    // Full-width square so the loop bound never truncates.
    assign sq_c    = SQ_W'(d_q) * SQ_W'(d_q);
    assign sq_gt_c = sq_c > SQ_W'(n_q);

    restoring_remainder #(.WIDTH(WIDTH)) u_rem (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_q),
        .dividend (n_q),
        .divisor  (d_q),
        .done     (div_done),
        .rem      (div_rem)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start) state_d = S_CLASSIFY;
            S_CLASSIFY: state_d = (n_q < WIDTH'(4)) ? S_FINISH : S_SQ_TEST;
            S_SQ_TEST:  state_d = sq_gt_c ? S_FINISH : S_DIV_WAIT;
            S_DIV_WAIT: if (div_done) state_d = (div_rem == '0) ? S_FINISH : S_NEXT;
            S_NEXT:     state_d = S_SQ_TEST;
            S_FINISH:   state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        n_d         = n_q;
        d_d         = d_q;
        trials_d    = trials_q;
        factor_d    = factor_q;
        is_prime_d  = is_prime_q;
        div_start_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d      = n;
                    trials_d = '0;
                end
            end
            S_CLASSIFY: begin
                d_d = WIDTH'(2);
                if (n_q < WIDTH'(2)) begin
                    is_prime_d = 1'b0;
                    factor_d   = '0;
                end else if (n_q < WIDTH'(4)) begin
                    is_prime_d = 1'b1;
                    factor_d   = n_q;
                end
            end
            S_SQ_TEST: begin
                if (sq_gt_c) begin
                    is_prime_d = 1'b1;
                    factor_d   = n_q;
                end else begin
                    div_start_d = 1'b1;
                    trials_d    = trials_q + WIDTH'(1);
                end
            end
            S_DIV_WAIT: begin
                if (div_done && (div_rem == '0)) begin
                    is_prime_d = 1'b0;
                    factor_d   = d_q;
                end
            end
            S_NEXT: begin
                d_d = d_q + WIDTH'(div_step(d_q == WIDTH'(2), ODD_ONLY));
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FINISH);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q         <= '0;
            d_q         <= '0;
            trials_q    <= '0;
            factor_q    <= '0;
            is_prime_q  <= 1'b0;
            div_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            n_q         <= n_d;
            d_q         <= d_d;
            trials_q    <= trials_d;
            factor_q    <= factor_d;
            is_prime_q  <= is_prime_d;
            div_start_q <= div_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign is_prime = is_prime_q;
    assign factor   = factor_q;
    assign trials   = trials_q;

endmodule

// File: tb/tb_prime_tester_param.sv
// Bench for prime_tester_param: odd-only and every-divisor instances side by side,
// compared against a plain-arithmetic trial-division model.
module tb_prime_tester_param;

    localparam int unsigned W      = 16;
    localparam int          BUDGET = 8000;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] n;

    logic         busy1, done1, prime1;
    logic [W-1:0] factor1, trials1;
    logic         busy0, done0, prime0;
    logic [W-1:0] factor0, trials0;

    int n_checks;
    int n_errors;
    int cur_n;

    prime_tester_param #(.WIDTH(W), .ODD_ONLY(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .n        (n),
        .busy     (busy1),
        .done     (done1),
        .is_prime (prime1),
        .factor   (factor1),
        .trials   (trials1)
    );

    prime_tester_param #(.WIDTH(W), .ODD_ONLY(1'b0)) dut_all (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .n        (n),
        .busy     (busy0),
        .done     (done0),
        .is_prime (prime0),
        .factor   (factor0),
        .trials   (trials0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s n=%0d got %0d expected %0d", tag, cur_n, got, exp);
        end
    endtask

    // Trial division straight from the definition.
    function automatic void model(input longint nv, input bit odd,
                                  output bit p, output longint f, output longint t);
        longint d;
        t = 0;
        if (nv < 2) begin
            p = 1'b0;
            f = 0;
            return;
        end
        p = 1'b1;
        f = nv;
        d = 2;
        while (d * d <= nv) begin
            t++;
            if (nv % d == 0) begin
                p = 1'b0;
                f = d;
                return;
            end
            d = (d == 2 || !odd) ? d + 1 : d + 2;
        end
    endfunction

    // Launch one test; optionally pulse a second start while busy (must be ignored).
    task automatic run_test(input logic [W-1:0] nv, input int inj_at, input logic [W-1:0] inj_n);
        bit     got1, got0, p;
        int     k1, k0;
        longint f, t;
        got1  = 1'b0;
        got0  = 1'b0;
        k1    = 0;
        k0    = 0;
        cur_n = int'(nv);
        @(negedge clk);
        start = 1'b1;
        n     = nv;
        for (int k = 1; k <= BUDGET; k++) begin
            @(negedge clk);
            if (k == inj_at) begin
                start = 1'b1;
                n     = inj_n;
            end else begin
                start = 1'b0;
            end
            if (k == 1) check("busy_after_start", 32'(busy1), 32'd1);
            if (got1 && k == k1 + 1) check("done_pulse_odd", 32'(done1), 32'd0);
            if (got0 && k == k0 + 1) check("done_pulse_all", 32'(done0), 32'd0);
            if (!got1 && done1) begin
                got1 = 1'b1;
                k1   = k;
                model(longint'(nv), 1'b1, p, f, t);
                check("prime_odd", 32'(prime1), 32'(p));
                check("factor_odd", 32'(factor1), 32'(f));
                check("trials_odd", 32'(trials1), 32'(t));
                if (nv < 4) check("latency_odd", 32'(k), 32'd2);
            end
            if (!got0 && done0) begin
                got0 = 1'b1;
                k0   = k;
                model(longint'(nv), 1'b0, p, f, t);
                check("prime_all", 32'(prime0), 32'(p));
                check("factor_all", 32'(factor0), 32'(f));
                check("trials_all", 32'(trials0), 32'(t));
                if (nv < 4) check("latency_all", 32'(k), 32'd2);
            end
            if (got1 && got0 && k > k1 && k > k0) break;
        end
        start = 1'b0;
        if (!got1) check("timeout_odd", 32'd0, 32'd1);
        if (!got0) check("timeout_all", 32'd0, 32'd1);
    endtask

    initial begin
        int          dones;
        logic [W-1:0] directed [12];
        n_checks = 0;
        n_errors = 0;
        cur_n    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        n        = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_prime", 32'(prime1), 32'd0);
        check("rst_factor", 32'(factor1), 32'd0);
        check("rst_trials", 32'(trials1), 32'd0);
        rst = 1'b0;

        directed = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd97,
                     16'd91, 16'd65535, 16'd65521, 16'd25, 16'd49, 16'd121};
        foreach (directed[i]) run_test(directed[i], 0, '0);

        for (int i = 0; i < 6; i++) run_test(W'($urandom_range(0, 65535)), 0, '0);
        for (int i = 0; i < 10; i++) run_test(W'($urandom_range(0, 1023)), 0, '0);

        // Leave non-zero results in place, then reset in the middle of a long test.
        run_test(16'd97, 0, '0);
        cur_n = 65521;
        @(negedge clk);
        start = 1'b1;
        n     = 16'd65521;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_busy", 32'(busy1), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_busy", 32'(busy1), 32'd0);
        check("mrst_prime", 32'(prime1), 32'd0);
        check("mrst_factor", 32'(factor1), 32'd0);
        check("mrst_trials", 32'(trials1), 32'd0);
        check("mrst_factor_all", 32'(factor0), 32'd0);
        rst   = 1'b0;
        dones = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done1 || done0 || busy1 || busy0) dones++;
        end
        check("no_done_after_rst", 32'(dones), 32'd0);

        // Start while busy is ignored; the first n decides the result.
        run_test(16'd91, 5, 16'd4);
        run_test(16'd91, 0, '0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
